// File: rtl/store_trace_fifo_if.sv
// Store-trace bus: processor store capture on one side, FIFO head/status on the other.
// drop_cnt exists only when STORE_TRACE_DROP_CNT_EN is defined.
interface store_trace_fifo_if #(
  parameter int unsigned DEPTH = 16
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          MemWrite;
  logic [31:0]   Adr;
  logic [31:0]   WriteData;
  logic [31:0]   PC;

  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_adr;
  logic [31:0]   out_data;
  logic [31:0]   out_pc;

  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
`ifdef STORE_TRACE_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  // Processor and consumer side.
  modport master (
    output MemWrite, Adr, WriteData, PC, out_ready,
    input  out_valid, out_adr, out_data, out_pc, count, full, empty, overflow
`ifdef STORE_TRACE_DROP_CNT_EN
    , input drop_cnt
`endif
  );

  // FIFO side.
  modport slave (
    input  MemWrite, Adr, WriteData, PC, out_ready,
    output out_valid, out_adr, out_data, out_pc, count, full, empty, overflow
`ifdef STORE_TRACE_DROP_CNT_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/store_trace_fifo.sv
// Captures processor stores whose address lies in [FILTER_LO, FILTER_HI] into a FIFO.
// Define STORE_TRACE_DROP_CNT_EN to add a saturating 16-bit dropped-store counter.
module store_trace_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] FILTER_LO = 32'h0000_0000,
  parameter logic [31:0] FILTER_HI = 32'hFFFF_FFFF
) (
  input logic               clk,
  input logic               reset,
  store_trace_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_overflow;

  logic [32:0]   w_lo_diff;
  logic [32:0]   w_hi_diff;
  logic          w_in_window;
  logic          w_push_req;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  entry_t        w_head;

  // Window check via 33-bit differences: a borrow means the address is out of range.
  assign w_lo_diff   = {1'b0, bus.Adr} - {1'b0, FILTER_LO};
  assign w_hi_diff   = {1'b0, FILTER_HI} - {1'b0, bus.Adr};
  assign w_in_window = !w_lo_diff[32] && !w_hi_diff[32];
  assign w_push_req  = bus.MemWrite && w_in_window;

  // Extra pointer MSB distinguishes full from empty across wraps.
  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);

  assign w_pop  = !w_empty && bus.out_ready && !reset;
  assign w_push = w_push_req && (!w_full || bus.out_ready) && !reset;
  assign w_drop = w_push_req && w_full && !bus.out_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage is intentionally not reset; it is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= '{adr: bus.Adr, data: bus.WriteData, pc: bus.PC};
    end
  end

  assign w_head = r_mem[w_rd_idx];

  assign bus.out_valid = !w_empty;
  assign bus.out_adr   = w_head.adr;
  assign bus.out_data  = w_head.data;
  assign bus.out_pc    = w_head.pc;
  assign bus.count     = r_wr_ptr - r_rd_ptr;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.overflow  = r_overflow;

`ifdef STORE_TRACE_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_store_trace_fifo.sv
// Bench for store_trace_fifo: a full-range DEPTH=16 instance and a windowed DEPTH=4
// instance share stimulus and are compared against queue-based reference models.
module tb_store_trace_fifo;
  localparam int unsigned DEPTH_A = 16;
  localparam int unsigned DEPTH_B = 4;
  localparam logic [31:0] LO_B    = 32'h0000_0100;
  localparam logic [31:0] HI_B    = 32'h0000_01FF;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        rdy_a;
  logic        rdy_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [95:0] qa[$];
  logic [95:0] qb[$];
  bit          ovf_a, ovf_b;
  int          drops_a, drops_b;

  store_trace_fifo_if #(.DEPTH(DEPTH_A)) if_a ();
  store_trace_fifo_if #(.DEPTH(DEPTH_B)) if_b ();

  assign if_a.MemWrite  = mem_write;
  assign if_a.Adr       = adr;
  assign if_a.WriteData = wdata;
  assign if_a.PC        = pc;
  assign if_a.out_ready = rdy_a;
  assign if_b.MemWrite  = mem_write;
  assign if_b.Adr       = adr;
  assign if_b.WriteData = wdata;
  assign if_b.PC        = pc;
  assign if_b.out_ready = rdy_b;

  store_trace_fifo #(.DEPTH(DEPTH_A)) u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (if_a)
  );

  store_trace_fifo #(.DEPTH(DEPTH_B), .FILTER_LO(LO_B), .FILTER_HI(HI_B)) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (if_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: pop first if the consumer takes a non-empty head, then the push either
  // fits or is dropped. A pop always frees room, so a full push+pop never drops.
  task automatic model_step();
    if (reset) begin
      qa.delete(); qb.delete();
      ovf_a = 1'b0; ovf_b = 1'b0;
      drops_a = 0;  drops_b = 0;
    end else begin
      if (rdy_a && qa.size() != 0) void'(qa.pop_front());
      if (rdy_b && qb.size() != 0) void'(qb.pop_front());
      if (mem_write) begin
        if (qa.size() < int'(DEPTH_A)) qa.push_back({adr, wdata, pc});
        else begin ovf_a = 1'b1; if (drops_a < 65535) drops_a++; end
        if (adr >= LO_B && adr <= HI_B) begin
          if (qb.size() < int'(DEPTH_B)) qb.push_back({adr, wdata, pc});
          else begin ovf_b = 1'b1; if (drops_b < 65535) drops_b++; end
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, " a.valid"}, 96'(if_a.out_valid), 96'(qa.size() != 0));
    check({ph, " a.count"}, 96'(if_a.count),     96'(qa.size()));
    check({ph, " a.full"},  96'(if_a.full),      96'(qa.size() == int'(DEPTH_A)));
    check({ph, " a.empty"}, 96'(if_a.empty),     96'(qa.size() == 0));
    check({ph, " a.ovf"},   96'(if_a.overflow),  96'(ovf_a));
    if (qa.size() != 0) check({ph, " a.head"}, {if_a.out_adr, if_a.out_data, if_a.out_pc}, qa[0]);
    check({ph, " b.valid"}, 96'(if_b.out_valid), 96'(qb.size() != 0));
    check({ph, " b.count"}, 96'(if_b.count),     96'(qb.size()));
    check({ph, " b.full"},  96'(if_b.full),      96'(qb.size() == int'(DEPTH_B)));
    check({ph, " b.empty"}, 96'(if_b.empty),     96'(qb.size() == 0));
    check({ph, " b.ovf"},   96'(if_b.overflow),  96'(ovf_b));
    if (qb.size() != 0) check({ph, " b.head"}, {if_b.out_adr, if_b.out_data, if_b.out_pc}, qb[0]);
`ifdef STORE_TRACE_DROP_CNT_EN
    check({ph, " a.drops"}, 96'(if_a.drop_cnt), 96'(drops_a));
    check({ph, " b.drops"}, 96'(if_b.drop_cnt), 96'(drops_b));
`endif
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input string ph);
    mem_write = 1'b1; adr = a; wdata = d; pc = 32'h8000_0000 | a;
    cycle(ph);
    mem_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_write = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    cycle("rst");
    reset = 1'b0;
  endtask

  logic [31:0] corners [4];

  initial begin
    reset = 1'b1; mem_write = 1'b0; adr = '0; wdata = '0; pc = '0;
    rdy_a = 1'b0; rdy_b = 1'b0;
    corners[0] = 32'h0FF; corners[1] = 32'h100; corners[2] = 32'h1FF; corners[3] = 32'h200;

    cycle("rst0");
    cycle("rst1");
    check("rst empty", 96'(if_a.empty), 96'(1));
    reset = 1'b0;

    // Three in-range stores with the consumer stalled.
    for (int i = 0; i < 3; i++) store(32'h40 + 32'(4 * i), 32'hA + 32'(i), "r038");
    cycle("r038 idle");
    check("r038 count", 96'(if_a.count),    96'(3));
    check("r038 adr",   96'(if_a.out_adr),  96'(32'h40));
    check("r038 data",  96'(if_a.out_data), 96'(32'hA));

    // Window boundaries on the filtered instance.
    do_reset();
    store(32'h0FC, 32'h1, "r039");
    store(32'h200, 32'h2, "r039");
    check("r039 empty", 96'(if_b.empty), 96'(1));
    store(32'h100, 32'h3, "r039");
    check("r039 count", 96'(if_b.count), 96'(1));

    // Fill to full, then one more without a pop.
    do_reset();
    for (int i = 0; i < 16; i++) store(32'h100 + 32'(4 * i), 32'(i), "r040 fill");
    store(32'h180, 32'hDEAD, "r040 drop");
    check("r040 full", 96'(if_a.full),     96'(1));
    check("r040 ovf",  96'(if_a.overflow), 96'(1));
    check("r040 head", 96'(if_a.out_adr),  96'(32'h100));
`ifdef STORE_TRACE_DROP_CNT_EN
    check("r040 drops", 96'(if_a.drop_cnt), 96'(1));
`endif

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 16; i++) store(32'h300 + 32'(4 * i), 32'(i), "r041 fill");
    rdy_a = 1'b1;
    store(32'h1F0, 32'h5A5A, "r041 pp");
    check("r041 count", 96'(if_a.count),    96'(16));
    check("r041 ovf",   96'(if_a.overflow), 96'(0));
    for (int i = 0; i < 15; i++) cycle("r041 drain");
    check("r041 last", 96'(if_a.out_adr), 96'(32'h1F0));
    cycle("r041 final");
    check("r041 empty", 96'(if_a.empty), 96'(1));

    // Streaming push/pop pairs across several pointer wraps.
    do_reset();
    rdy_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      store(32'h2000 + 32'(4 * i), 32'(i), "r042");
      check("r042 cnt<=1", 96'(if_a.count <= 1), 96'(1));
      check("r042 head",   96'(if_a.out_adr),    96'(32'h2000 + 32'(4 * i)));
    end

    // Reset beats a simultaneous push.
    do_reset();
    for (int i = 0; i < 5; i++) store(32'h500 + 32'(4 * i), 32'(i), "r043 fill");
    check("r043 count5", 96'(if_a.count), 96'(5));
    reset = 1'b1; mem_write = 1'b1; adr = 32'h600;
    cycle("r043 rst");
    reset = 1'b0; mem_write = 1'b0;
    check("r043 count", 96'(if_a.count),    96'(0));
    check("r043 empty", 96'(if_a.empty),    96'(1));
    check("r043 ovf",   96'(if_a.overflow), 96'(0));

    // Randomized traffic, sparse ready early to force overflow, dense later.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      mem_write = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       adr = $urandom;
        1:       adr = 32'h0F0 + 32'($urandom_range(0, 32'h120));
        default: adr = corners[$urandom_range(0, 3)];
      endcase
      wdata = $urandom;
      pc    = $urandom;
      rdy_a = ($urandom_range(0, 99) < ((n < 1500) ? 30 : 75));
      rdy_b = ($urandom_range(0, 99) < ((n < 1500) ? 40 : 80));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/store_trace_fifo.md
STORE_TRACE_FIFO -- requirements
Module: store_trace_fifo

Interface
REQ-001 Parameter DEPTH, 16: FIFO entries; power of two, 2..256.
REQ-002 Parameter FILTER_LO, 32'h0000_0000: lowest captured store address, inclusive.
REQ-003 Parameter FILTER_HI, 32'hFFFF_FFFF: highest captured store address, inclusive.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 MemWrite  input  1: processor store strobe.
REQ-007 Adr  input  32: store address, qualified by MemWrite.
REQ-008 WriteData  input  32: store data, qualified by MemWrite.
REQ-009 PC  input  32: processor PC sampled with the store.
REQ-010 out_valid  output  1: head entry available.
REQ-011 out_ready  input  1: consumer accepts the head entry.
REQ-012 out_adr  output  32: head entry address.
REQ-013 out_data  output  32: head entry data.
REQ-014 out_pc  output  32: head entry PC.
REQ-015 count  output  log2(DEPTH)+1: current occupancy.
REQ-016 full  output  1: count equals DEPTH.
REQ-017 empty  output  1: count equals 0.
REQ-018 overflow  output  1: sticky flag, set when a store is dropped.
REQ-019 drop_cnt  output  16: dropped-store counter; present only per REQ-036.

Function
REQ-020 Capture condition: MemWrite high and FILTER_LO <= Adr <= FILTER_HI, unsigned compare; this is a push request.
REQ-021 An accepted push writes {Adr, WriteData, PC} at the tail in the same edge; the tail pointer advances modulo DEPTH.
REQ-022 A pop occurs when out_valid and out_ready are both high at the edge; the head pointer advances modulo DEPTH.
REQ-023 out_valid equals !empty; out_adr/out_data/out_pc show the head entry combinationally from storage.
REQ-024 Latency: an entry pushed at edge N is visible at the outputs with out_valid high after edge N; no bypass in the push cycle.
REQ-025 Outputs are stable while out_valid is high and out_ready is low.
REQ-026 Simultaneous push and pop, not full: both take effect and count is unchanged.
REQ-027 Simultaneous push and pop while full: the pop frees a slot, the push is accepted, count stays DEPTH, and no drop occurs.
REQ-028 Push while full without a pop: the entry is dropped, storage and pointers are unchanged, and overflow is set.
REQ-029 Pop while empty: impossible, because out_valid is low; pointers are unchanged.
REQ-030 Pointer wrap: pointers carry one extra bit; full and empty come from pointer compare, so they are correct across any number of wraps.
REQ-031 Non-qualifying MemWrite (outside the filter) has no effect on any state.

Reset
REQ-032 On reset high at an edge: head = tail = 0, count = 0, empty = 1, full = 0, out_valid = 0, overflow = 0, drop_cnt = 0.
REQ-033 Reset takes priority over a simultaneous push or pop; in-flight entries are discarded.
REQ-034 Storage array contents are not reset; they are not observable while empty.
REQ-035 out_adr/out_data/out_pc are don't-care while out_valid = 0.

Configuration
REQ-036 Macro STORE_TRACE_DROP_CNT_EN: when defined, drop_cnt increments by 1 on each REQ-028 drop and saturates at 16'hFFFF.
REQ-037 Without STORE_TRACE_DROP_CNT_EN: the drop_cnt port and its counter are absent; overflow behaviour is unchanged.

Verification
REQ-038 After reset, 3 in-range stores (Adr 0x40/0x44/0x48, data 0xA/0xB/0xC) with out_ready = 0 -> count = 3; out_adr = 0x40, out_data = 0xA.
REQ-039 FILTER_LO = 0x100, FILTER_HI = 0x1FF; stores to 0x0FC and 0x200 -> empty stays 1; store to 0x100 -> count = 1.
REQ-040 DEPTH = 16: 16 stores, then a 17th with out_ready = 0 -> full = 1, overflow = 1, drop_cnt = 1 (macro defined), head still holds the 1st entry.
REQ-041 Full, with push and out_ready = 1 in the same cycle -> count stays 16, overflow stays 0, and the new entry appears last after 16 pops.
REQ-042 40 push/pop pairs with out_ready = 1 continuously -> every entry emerges in order, pointers wrap and count never exceeds 1.
REQ-043 Reset asserted with count = 5 and a simultaneous push -> next cycle count = 0, empty = 1, overflow = 0.
